// File: rtl/pulse_pkg.sv
// Shared pulse generator / measurement types.
// FSM state encoding and synchronizer depth.
package pulse_pkg;

  localparam int SYNC_STAGES = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACTIVE,
    ST_INACTIVE,
    ST_ERR
  } state_t;

endpackage

// File: rtl/pulse_edge.sv
// Synchronizes cki into clk, keeps a hold-able edge register and decodes
// active/inactive edges relative to the idle level v1_i.
module pulse_edge
  import pulse_pkg::*;
(
  input  logic clk_i,
  input  logic rst_i,
  input  logic cki_i,
  input  logic v1_i,
  input  logic hold_i,
  output logic s_o,
  output logic act_o,
  output logic inact_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_d_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      s_d_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], cki_i};
      // Holding s_d lets an edge that happens during halt
      // show up on the first unhalted cycle.
      if (!hold_i) s_d_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s_o     = sync_q[SYNC_STAGES-1];
  assign act_o   = (s_d_q == v1_i) && (s_o != v1_i);
  assign inact_o = (s_d_q != v1_i) && (s_o == v1_i);

endmodule

// File: rtl/pulse_meas.sv
// Pulse measurement receiver: delay from arm, active width, period.
// Ports: clk/rst, setb arm, v1 idle level, halt/haltena, cki in;
// td/pw/period/cnt/cycle results, rise/fall/valid strobes, err.
module pulse_meas
  import pulse_pkg::*;
#(
  parameter int MSB      = 7,
  parameter int CYCLEMSB = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              setb,
  input  logic              v1,
  input  logic              halt,
  input  logic              haltena,
  input  logic              cki,
  output logic [MSB:0]      td,
  output logic [MSB:0]      pw,
  output logic [MSB:0]      period,
  output logic [MSB:0]      cnt,
  output logic [CYCLEMSB:0] cycle,
  output logic              rise,
  output logic              fall,
  output logic              valid,
  output logic              err
);

  localparam logic [MSB:0] ONE = (MSB+1)'(1);
  localparam logic [MSB:0] MAX = '1;
  localparam logic [CYCLEMSB:0] C1 = (CYCLEMSB+1)'(1);

  state_t state_q, state_d;
  logic [MSB:0] td_q, td_d, pw_q, pw_d;
  logic [MSB:0] per_q, per_d;
  logic [MSB:0] cnt_q, cnt_d, ph_q, ph_d;
  logic [MSB:0] cnt_inc, ph_inc;
  logic [CYCLEMSB:0] cyc_q, cyc_d;
  logic err_q, err_d, val_q, val_d;
  logic frz, s, act, inact;

  assign frz = halt && haltena;

  pulse_edge u_edge (
    .clk_i   (clk),
    .rst_i   (rst),
    .cki_i   (cki),
    .v1_i    (v1),
    .hold_i  (frz),
    .s_o     (s),
    .act_o   (act),
    .inact_o (inact)
  );

  // cnt never wraps; ph stops short of wrap via err.
  assign cnt_inc = (cnt_q == MAX) ? cnt_q : cnt_q + ONE;
  assign ph_inc  = ph_q + ONE;

  always_comb begin
    state_d = state_q;
    td_d    = td_q;
    pw_d    = pw_q;
    per_d   = per_q;
    cnt_d   = cnt_q;
    ph_d    = ph_q;
    cyc_d   = cyc_q;
    err_d   = err_q;
    val_d   = 1'b0;
    if (!setb) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      ph_d    = '0;
      cyc_d   = '0;
      err_d   = 1'b0;
    end else if (!frz) begin
      unique case (state_q)
        ST_IDLE, ST_WAIT: begin
          state_d = ST_WAIT;
          cnt_d   = cnt_inc;
          if (act) begin
            td_d    = cnt_q;
            ph_d    = ONE;
            state_d = ST_ACTIVE;
          end else if (cnt_inc == MAX) begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end
        end
        ST_ACTIVE: begin
          cnt_d = cnt_inc;
          ph_d  = ph_inc;
          if (inact) begin
            pw_d    = ph_q;
            state_d = ST_INACTIVE;
          end else if (ph_inc == MAX) begin
            err_d   = 1'b1;
            state_d = ST_ERR;
          end
        end
        ST_INACTIVE: begin
          cnt_d = cnt_inc;
          if (act) begin
            per_d   = ph_q;
            ph_d    = ONE;
            cyc_d   = cyc_q + C1;
            val_d   = 1'b1;
            state_d = ST_ACTIVE;
          end else begin
            ph_d = ph_inc;
            if (ph_inc == MAX) begin
              err_d   = 1'b1;
              state_d = ST_ERR;
            end
          end
        end
        ST_ERR: ;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      td_q    <= '0;
      pw_q    <= '0;
      per_q   <= '0;
      cnt_q   <= '0;
      ph_q    <= '0;
      cyc_q   <= '0;
      err_q   <= 1'b0;
      val_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      td_q    <= td_d;
      pw_q    <= pw_d;
      per_q   <= per_d;
      cnt_q   <= cnt_d;
      ph_q    <= ph_d;
      cyc_q   <= cyc_d;
      err_q   <= err_d;
      val_q   <= val_d;
    end
  end

  logic live;
  assign live = setb && (state_q != ST_ERR) && !frz;

  assign rise   = live && act;
  assign fall   = live && inact;
  assign td     = td_q;
  assign pw     = pw_q;
  assign period = per_q;
  assign cnt    = cnt_q;
  assign cycle  = cyc_q;
  assign valid  = val_q;
  assign err    = err_q;

  logic unused;
  assign unused = s;

endmodule
